peripheral_ram_slave_ahb3: RTL
==============================

// Module: peripheral_ram_slave_ahb3
// PURPOSE
//  AHB3-Lite slave front end for the byte-write, separate-read-port generic RAM.
//  Decodes address/data phases and converts HSIZE/HADDR into byte write enables.
//  Drives the RAM write and read ports with zero wait states, including
//  write-to-read forwarding. Sits between the AHB3 interconnect and one RAM instance.
// PARAMETERS
//  DEPTH       256            RAM depth in 32-bit words
//  AW          $clog2(DEPTH)  RAM word-address width
//  HADDR_SIZE  32             AHB address width
//  DW          32             data width (only 32 supported)
// PORTS
//  HCLK       in   1        clock, all state on rising edge
//  HRESETn    in   1        asynchronous active-low reset
//  HSEL       in   1        slave select
//  HADDR      in   HADDR_SIZE  byte address
//  HWDATA     in   DW       write data (data phase)
//  HRDATA     out  DW       read data (data phase)
//  HWRITE     in   1        1=write, 0=read
//  HSIZE      in   3        0=byte, 1=half, 2=word
//  HBURST     in   3        ignored (every beat decoded independently)
//  HPROT      in   4        ignored
//  HTRANS     in   2        0=IDLE 1=BUSY 2=NONSEQ 3=SEQ
//  HREADY     in   1        bus ready (address phase accepted when high)
//  HREADYOUT  out  1        slave ready
//  HRESP      out  1        0=OKAY 1=ERROR
//  ram_we     out  4        RAM byte write enables
//  ram_din    out  DW       RAM write data
//  ram_waddr  out  AW       RAM write word address
//  ram_raddr  out  AW       RAM read word address
//  ram_dout   in   DW       RAM read data (1-cycle registered)
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, ram_we=0, state=IDLE, phase regs and forward flag clear.
//  Accept = HSEL & HREADY & HTRANS[1]. IDLE/BUSY or HSEL=0: OKAY, no RAM write.
//  Byte mask from address phase: byte -> 4'b0001<<HADDR[1:0];
//   half -> 4'b0011<<{HADDR[1],1'b0}; word -> 4'hF. Misaligned: address aligned down.
//  Write: accepted address phase registers waddr=HADDR[AW+1:2], mask.
//   Next cycle (data phase): ram_we=mask, ram_din=HWDATA, ram_waddr=registered addr.
//   Write commits at end of data phase. ram_we=0 in all other cycles.
//  Read: ram_raddr=HADDR[AW+1:2] combinational every cycle. HRDATA=ram_dout in the
//   data phase, 0 wait states. HRDATA is don't-care outside a read data phase.
//  Forwarding: read accepted while write data phase to same word is in progress ->
//   next cycle HRDATA=(ram_dout & ~m)|(wd_q & m). m and wd_q are the write's
//   bit-expanded mask and HWDATA, registered at that edge.
//  FSM: IDLE -> DATA on accept (OKAY). DATA -> DATA on accept, else IDLE.
//   Error path: ERR1 (HREADYOUT=0, HRESP=1) -> ERR2 (HREADYOUT=1, HRESP=1) -> IDLE/DATA.
//  Back-to-back transfers: no bubbles. Write followed by read handled by forwarding.
//  HREADY low from another slave: no accept. An already pending data phase still
//   completes this cycle (our HREADYOUT=1).
//  Async reset mid-transfer: in-flight write dropped (ram_we=0 immediately), FSM to IDLE.
// CONFIGURATION
//  AHB3_RAM_ERROR_EN defined: accepted transfer returns a 2-cycle ERROR and no
//   RAM write if any of these hold:
//   - HADDR >= DEPTH*4
//   - HSIZE > 2
//   - misaligned (half with HADDR[0]; word with HADDR[1:0]!=0)
//  AHB3_RAM_ERROR_EN undefined: no ERR states. HRESP tied 0, HREADYOUT tied 1.
//   Address wraps modulo DEPTH*4. HSIZE>2 treated as word. Misaligned aligned down.
// TESTING
//  word write 0x10=0xDEADBEEF, later read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 throughout
//  byte write 0x13=0xAA over 0x11223344, read 0x10 -> 0xAA223344, ram_we=4'b1000 once
//  half write 0x22=0xBEEF over 0, immediately followed by read 0x20 -> 0xBEEF0000 (forwarded)
//  HTRANS=BUSY/IDLE with HSEL=1,HWRITE=1 -> ram_we stays 0, HRESP=0, memory unchanged
//  AHB3_RAM_ERROR_EN on, write HADDR=DEPTH*4 -> HREADYOUT 0 then 1 with HRESP=1 both cycles, no ram_we
//  HRESETn low during write data phase -> ram_we=0 same cycle, HREADYOUT=1, HRESP=0, FSM IDLE

Source files
------------

// File: rtl/peripheral_ram_slave_ahb3.sv
// -----------------------------------------------------------------------------
// peripheral_ram_slave_ahb3
//   AHB3-Lite slave front end for a byte-write RAM with a separate,
//   1-cycle-registered read port. Every beat is decoded on its own. Writes are
//   presented to the RAM in the AHB data phase with zero wait states. A read
//   that immediately follows a write to the same word is patched with the
//   write's bytes, because the RAM read returns pre-write contents.
//
//   Optional feature macro: AHB3_RAM_ERROR_EN
//     defined   : out-of-range, HSIZE>2 or misaligned transfers get a
//                 two-cycle ERROR response and never write the RAM.
//     undefined : HRESP=0, HREADYOUT=1, the address wraps, HSIZE>2 acts as a
//                 word, and misaligned addresses are aligned down.
//
// Ports
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HSEL..HREADY          AHB3-Lite slave inputs (HBURST/HPROT unused)
//   HRDATA, HREADYOUT,
//   HRESP                 AHB3-Lite slave outputs
//   ram_we, ram_din,
//   ram_waddr             RAM write port (byte enables, data, word address)
//   ram_raddr, ram_dout   RAM read port (address in, data back one cycle later)
// -----------------------------------------------------------------------------
module peripheral_ram_slave_ahb3 #(
   parameter int DEPTH      = 256,
   parameter int AW         = $clog2(DEPTH),
   parameter int HADDR_SIZE = 32,
   parameter int DW         = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [DW-1:0]         HWDATA,
   output logic [DW-1:0]         HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [3:0]            ram_we,
   output logic [DW-1:0]         ram_din,
   output logic [AW-1:0]         ram_waddr,
   output logic [AW-1:0]         ram_raddr,
   input  logic [DW-1:0]         ram_dout
);

   // ---------------------------------------------------------------------------
   // FSM state encoding
   // ---------------------------------------------------------------------------
`ifdef AHB3_RAM_ERROR_EN
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_DATA} state_t;
`endif

   state_t state_q;

   // ---------------------------------------------------------------------------
   // Address-phase decode
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] byte_mask(input logic [2:0] size,
                                            input logic [1:0] a);
      case (size)
         3'd0:    byte_mask = 4'b0001 << a;
         3'd1:    byte_mask = 4'b0011 << {a[1], 1'b0};
         default: byte_mask = 4'hF;   // word, and HSIZE>2 when errors are off
      endcase
   endfunction

   function automatic logic [DW-1:0] bit_mask(input logic [3:0] m);
      for (int b = 0; b < 4; b++) bit_mask[8*b +: 8] = {8{m[b]}};
   endfunction

   logic          acc;     // address phase accepted this cycle
   logic          bad;     // accepted transfer must get ERROR
   logic [3:0]    mask;
   logic [AW-1:0] haddr_word;

   assign mask       = byte_mask(HSIZE, HADDR[1:0]);
   assign haddr_word = HADDR[AW+1:2];

`ifdef AHB3_RAM_ERROR_EN
   localparam logic [HADDR_SIZE:0] RAM_BYTES = (HADDR_SIZE+1)'(DEPTH * 4);

   // ERR1 holds HREADYOUT low, so no address phase can be taken there.
   assign acc = HSEL & HREADY & HTRANS[1] & (state_q != S_ERR1);
   assign bad = ({1'b0, HADDR} >= RAM_BYTES)
              | (HSIZE > 3'd2)
              | ((HSIZE == 3'd1) & HADDR[0])
              | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`else
   assign acc = HSEL & HREADY & HTRANS[1];
   assign bad = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Data-phase pipeline registers
   // ---------------------------------------------------------------------------
   logic          wr_pend_q, wr_pend_d;   // write data phase in this cycle
   logic [AW-1:0] waddr_q;
   logic [3:0]    mask_q;
   logic          fwd_q, fwd_d;           // read data phase needs write bytes
   logic [DW-1:0] fmask_q;
   logic [DW-1:0] fdata_q;

   assign wr_pend_d = acc & HWRITE & ~bad;

   // The RAM commits the pending write at the same edge it samples the read
   // address, so it hands back the old word; remember the write to merge it.
   assign fwd_d = acc & ~HWRITE & ~bad & wr_pend_q & (waddr_q == haddr_word);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_pend_q <= 1'b0;
         waddr_q   <= '0;
         mask_q    <= '0;
         fwd_q     <= 1'b0;
         fmask_q   <= '0;
         fdata_q   <= '0;
      end else begin
         wr_pend_q <= wr_pend_d;
         if (wr_pend_d) begin
            waddr_q <= haddr_word;
            mask_q  <= mask;
         end
         fwd_q <= fwd_d;
         if (fwd_d) begin
            fmask_q <= bit_mask(mask_q);
            fdata_q <= HWDATA;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM with registered response outputs
   // ---------------------------------------------------------------------------
`ifdef AHB3_RAM_ERROR_EN
   logic hreadyout_q;
   logic hresp_q;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= S_IDLE;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
      end else begin
         case (state_q)
            S_ERR1: begin
               state_q     <= S_ERR2;
               hreadyout_q <= 1'b1;
               hresp_q     <= 1'b1;
            end
            default: begin   // IDLE, DATA, ERR2 can all take a new beat
               if (acc && bad) begin
                  state_q     <= S_ERR1;
                  hreadyout_q <= 1'b0;
                  hresp_q     <= 1'b1;
               end else begin
                  state_q     <= acc ? S_DATA : S_IDLE;
                  hreadyout_q <= 1'b1;
                  hresp_q     <= 1'b0;
               end
            end
         endcase
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
`else
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= S_IDLE;
      else          state_q <= acc ? S_DATA : S_IDLE;
   end

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // RAM ports and read data
   // ---------------------------------------------------------------------------
   assign ram_we    = wr_pend_q ? mask_q : 4'b0000;
   assign ram_din   = HWDATA;
   assign ram_waddr = waddr_q;
   assign ram_raddr = haddr_word;

   assign HRDATA = fwd_q ? ((ram_dout & ~fmask_q) | (fdata_q & fmask_q))
                         : ram_dout;

   // Inputs the protocol hands us but this slave has no use for.
   logic unused_in;
   assign unused_in = ^{HBURST, HPROT, HTRANS[0], HADDR, state_q};

endmodule
